// File: rtl/frame_capture_ctrl_pkg.sv
// Shared types and constants for the frame capture write sequencer.
// Defining DECIMATE_EN selects 2:1 decimation in both directions (S=2); otherwise 1:1 crop.
package buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SRC_CNT_W  = 10;
  localparam int BUF_ADDR_W = 8;

`ifdef DECIMATE_EN
  localparam int DEC_S = 2;
`else
  localparam int DEC_S = 1;
`endif

  localparam int DEC_SHIFT = DEC_S - 1;

  // Source counters stick at full scale rather than wrapping back into the window.
  function automatic logic [SRC_CNT_W-1:0] sat_inc(input logic [SRC_CNT_W-1:0] v);
    return (v == {SRC_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_sync_edge.sv
// One-stage register on a camera-domain level with rise/fall strobes
// derived from the current input against its registered copy.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_d <= 1'b0;
    else     r_d <= i_d;
  end

  assign o_rise = i_d & ~r_d;
  assign o_fall = ~i_d & r_d;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Crops a window out of the camera pixel stream and drives the frame buffer write port.
// Build option DECIMATE_EN keeps every other pixel of every other line.
//   state  | meaning
//   IDLE   | capture disabled
//   SYNC   | armed, waiting for vsync to fall
//   ACTIVE | writing window pixels of the current frame
//   DONE   | window complete, waiting for vsync to rise
module frame_capture_ctrl
  import buffer_ctrl_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int WIN_W  = 150,
  parameter int WIN_H  = 150,
  parameter int WIN_X0 = 245,
  parameter int WIN_Y0 = 165
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic                  vsync,
  input  logic                  href,
  input  logic                  pix_valid,
  input  logic [15:0]           pix_data,
  output logic [BUF_ADDR_W-1:0] w_addr_r,
  output logic [BUF_ADDR_W-1:0] w_addr_c,
  output logic                  w_en,
  output logic [15:0]           w_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int X_END = WIN_X0 + WIN_W * DEC_S;
  localparam int Y_END = WIN_Y0 + WIN_H * DEC_S;
  localparam logic [SRC_CNT_W-1:0]  X0     = SRC_CNT_W'(WIN_X0);
  localparam logic [SRC_CNT_W-1:0]  Y0     = SRC_CNT_W'(WIN_Y0);
  localparam logic [BUF_ADDR_W-1:0] LAST_C = BUF_ADDR_W'(WIN_W - 1);
  localparam logic [BUF_ADDR_W-1:0] LAST_R = BUF_ADDR_W'(WIN_H - 1);

  state_t r_state, w_next;

  logic w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall;
  logic w_unused;
  logic [SRC_CNT_W-1:0]  r_col, r_row, w_off_c, w_off_r;
  logic [BUF_ADDR_W-1:0] w_ac, w_ar;
  logic w_px, w_in_win, w_phase_ok, w_hit, w_last;

  logic [BUF_ADDR_W-1:0] r_addr_r, r_addr_c;
  logic [15:0]           r_data;
  logic                  r_w_en, r_busy, r_done, r_err;

  sync_edge u_vsync_edge (.clk(clk), .rst(rst), .i_d(vsync), .o_rise(w_vs_rise), .o_fall(w_vs_fall));
  sync_edge u_href_edge  (.clk(clk), .rst(rst), .i_d(href),  .o_rise(w_hs_rise), .o_fall(w_hs_fall));

  // Line starts are implied by pixels arriving with href high.
  assign w_unused = w_hs_rise;

  assign w_px = pix_valid & href;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (w_hs_fall)  r_col <= '0;
      else if (w_px)  r_col <= sat_inc(r_col);
      if (w_vs_fall)      r_row <= '0;
      else if (w_hs_fall) r_row <= sat_inc(r_row);
    end
  end

  assign w_off_c = r_col - X0;
  assign w_off_r = r_row - Y0;
  assign w_ac    = BUF_ADDR_W'(w_off_c >> DEC_SHIFT);
  assign w_ar    = BUF_ADDR_W'(w_off_r >> DEC_SHIFT);

  assign w_in_win = (int'(r_col) >= WIN_X0) && (int'(r_col) < X_END) && (int'(r_col) < IMG_W) &&
                    (int'(r_row) >= WIN_Y0) && (int'(r_row) < Y_END) && (int'(r_row) < IMG_H);

`ifdef DECIMATE_EN
  assign w_phase_ok = ~w_off_c[0] & ~w_off_r[0];
`else
  assign w_phase_ok = 1'b1;
`endif

  assign w_hit  = w_px & w_in_win & w_phase_ok & (r_state == ACTIVE);
  assign w_last = w_hit & (w_ac == LAST_C) & (w_ar == LAST_R);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cap_en) w_next = SYNC;
      SYNC:    if (!cap_en) w_next = IDLE;
               else if (w_vs_fall) w_next = ACTIVE;
      ACTIVE:  if (w_last) w_next = DONE;
               else if (w_vs_rise) w_next = SYNC;
      DONE:    if (w_vs_rise) w_next = cap_en ? SYNC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr_r <= '0;
      r_addr_c <= '0;
      r_data   <= '0;
      r_w_en   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_w_en  <= w_hit;
      if (w_hit) begin
        r_addr_r <= w_ar;
        r_addr_c <= w_ac;
        r_data   <= pix_data;
      end
      r_done <= w_last;
      r_err  <= (r_state == ACTIVE) & w_vs_rise & ~w_last;
      // Held through the cycle that carries the final write and frame_done.
      r_busy <= (w_next == ACTIVE) | w_last;
    end
  end

  assign w_addr_r   = r_addr_r;
  assign w_addr_c   = r_addr_c;
  assign w_en       = r_w_en;
  assign w_data     = r_data;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign frame_err  = r_err;

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Write-side sequencer for the dual-clock frame buffer. Consumes the OV7670 pixel stream (vsync, href, assembled 16-bit RGB565 pixels with a valid strobe) in the camera pixel clock domain. Crops a fixed window out of each frame and drives the buffer's write port: row/column address, write enable and data. Also provides frame-level status (busy, done, error) to the top level and the VGA side.

## Interface
Parameters:
- IMG_W, 640, source active pixels per line
- IMG_H, 480, source active lines per frame
- WIN_W, 150, window width in buffer columns (≤ 256)
- WIN_H, 150, window height in buffer rows (≤ 256)
- WIN_X0, 245, first source column of the window
- WIN_Y0, 165, first source line of the window

Ports:
- clk  in  1  camera-domain pixel clock (buffer w_clk); one clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cap_en  in  1  level; 1 = capture frames continuously, 0 = stop after current frame
- vsync  in  1  high during vertical blanking
- href  in  1  high during active line
- pix_valid  in  1  one-cycle strobe, pix_data valid
- pix_data  in  16  RGB565 pixel
- w_addr_r  out  8  buffer write row
- w_addr_c  out  8  buffer write column
- w_en  out  1  buffer write enable
- w_data  out  16  buffer write data
- busy  out  1  high in ACTIVE
- frame_done  out  1  one-cycle pulse, window completely written
- frame_err  out  1  one-cycle pulse, frame aborted by early vsync

## Operation
- vsync and href are registered once (vsync_d, href_d). Edges are derived from current vs. registered value.
- Source counters (10 bits, saturate at 1023):
  - col: +1 on every pix_valid while href=1; cleared on href falling edge.
  - row: +1 on href falling edge; cleared on vsync falling edge.
- Window hit: WIN_X0 ≤ col < WIN_X0+WIN_W·S and WIN_Y0 ≤ row < WIN_Y0+WIN_H·S.
  - S = 1, or 2 with decimation.
  - With S=2, hit additionally requires (col−WIN_X0) and (row−WIN_Y0) even.
- On hit in ACTIVE: w_addr_c=(col−WIN_X0)>>(S−1), w_addr_r=(row−WIN_Y0)>>(S−1), w_data=pix_data, w_en=1. Otherwise w_en=0; addresses/data hold.
- FSM:
  - IDLE → SYNC when cap_en=1.
  - SYNC → ACTIVE on vsync falling edge.
  - ACTIVE → DONE on the write to (WIN_H−1, WIN_W−1); frame_done pulses with that write.
  - ACTIVE → SYNC on vsync rising edge before done; frame_err pulses for 1 cycle.
  - DONE → SYNC on vsync rising edge if cap_en=1, else → IDLE.
  - cap_en falling in SYNC → IDLE. In ACTIVE it is ignored until the frame ends.
- Pixels outside ACTIVE are never written. A window exceeding the source (WIN_X0+WIN_W·S > IMG_W) never completes; each frame ends in frame_err.
- pix_valid with href=0 is ignored; counters do not move.

## Timing
- Reset values: state IDLE; counters 0; w_addr_r=0, w_addr_c=0, w_data=0, w_en=0, busy=0, frame_done=0, frame_err=0.
- All outputs are registered. Latency pix_valid → w_en is exactly 1 clk, same cycle for addresses and data.
- Edge detection adds 1 clk. The first pixel is accepted only if it arrives ≥ 1 clk after vsync falls.
- frame_done and frame_err are never asserted in the same cycle.
- busy is high from the cycle after the vsync falling edge through the frame_done cycle.
- Reset mid-frame: everything returns to reset values immediately. The next capture starts at the following vsync falling edge.

## Configuration
- DECIMATE_EN defined: S=2. Every other pixel of every other line is kept, so the window spans 2·WIN_W × 2·WIN_H source pixels.
- DECIMATE_EN undefined: S=1, 1:1 crop. The even-offset check and shifts are compiled out.

## Structure
- Package buffer_ctrl_pkg holds:
  - the FSM state enum (IDLE, SYNC, ACTIVE, DONE);
  - SRC_CNT_W=10 and BUF_ADDR_W=8;
  - the decimation-factor localparam derived from DECIMATE_EN.
- One sub-module, sync_edge: single-bit register with rise/fall outputs. Instantiated for vsync and href.

## Test plan
Default test parameters: IMG_W=16, IMG_H=8, WIN_W=4, WIN_H=4, WIN_X0=2, WIN_Y0=1, DECIMATE_EN undefined.
- Reset mid-ACTIVE (rst pulse during line 3) -> all outputs 0 immediately; state IDLE; no writes until the next vsync falling edge.
- Full frame, cap_en=1 -> exactly 16 writes with addresses (0,0)..(3,3) in row-major order; w_data equals source pixel (row 1..4, col 2..5); one frame_done on the write to (3,3).
- vsync rises after line 2 -> frame_err pulses once; no frame_done; next frame captured cleanly.
- cap_en dropped mid-frame -> current frame completes with frame_done; FSM goes to IDLE; the following frame produces zero writes.
- DECIMATE_EN defined, same parameters with IMG_W=16 -> source (row 3, col 6) writes to (1,2); odd offsets are never written; 16 writes total.
- pix_valid with href=0, and back-to-back pix_valid every clk -> ignored strobes cause no counter change; consecutive pixels write consecutive columns with 1 clk latency.
